// File: rtl/if_fetch_gen.sv
// Instruction-fetch PC generator: aligned group fetch, held redirects and
// delay-slot sequencing between the BPU, I-cache and EX/CP0 redirect sources.
module if_fetch_gen #(
  parameter int unsigned      ADDR_W       = 32,
  parameter int unsigned      FETCH_W      = 4,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'hBFC0_0000
) (
  input  logic                      clk,
  input  logic                      rst_,
  input  logic                      exc_flush_all,
  input  logic [ADDR_W-1:0]         cp0_if_excaddr,
  input  logic                      ex_bp_error,
  input  logic [ADDR_W-1:0]         ex_new_target,
  input  logic                      ex_delot_en,
  input  logic [ADDR_W-1:0]         ex_delot_pc,
  input  logic                      bp_if_en,
  input  logic [ADDR_W-1:0]         bp_if_target,
  input  logic                      bp_if_delot_en,
  input  logic [ADDR_W-1:0]         bp_if_delot_pc,
  input  logic                      icache_allin,
  input  logic                      bp_allin,
  output logic [ADDR_W-1:0]         if_pc,
  output logic                      if_valid_ns,
  output logic [$clog2(FETCH_W):0]  if_word_cnt,
  output logic [1:0]                if_icache_delot_en,
  output logic                      flush_pending,
  output logic                      refetch_flag
);

  localparam int unsigned OFF_W  = $clog2(FETCH_W);
  localparam int unsigned CNT_W  = OFF_W + 1;
  localparam int unsigned GRP_SH = OFF_W + 2;

  typedef enum logic [1:0] {RUN, HOLD, DSLOT_EX, DSLOT_BP} state_t;

  // Words remaining in the aligned group starting at pc.
  function automatic logic [CNT_W-1:0] grp_cnt(input logic [ADDR_W-1:0] pc);
    logic [ADDR_W-1:0] off;
    off = (pc >> 2) & ADDR_W'(FETCH_W - 1);
    return CNT_W'(FETCH_W) - CNT_W'(off);
  endfunction

  function automatic logic [ADDR_W-1:0] seq_pc(input logic [ADDR_W-1:0] pc);
    return ((pc >> GRP_SH) + ADDR_W'(1)) << GRP_SH;
  endfunction

  state_t            state_q, state_d, nstate;
  logic [ADDR_W-1:0] pc_q, pc_d, npc;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        delot_q, delot_d;
  logic              fp_q, fp_d;
  logic              refetch_q, refetch_d;
  logic              valid_q;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic              pend_ds_q, pend_ds_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
  logic              pend_exc_q, pend_exc_d;
  logic [ADDR_W-1:0] dslot_tgt_q, dslot_tgt_d;
  logic              advance;
  logic              mispredict;
  logic              redir;

  assign advance = valid_q & icache_allin & bp_allin;
  // A latched exception must not be displaced by a younger mispredict.
  assign mispredict = ex_bp_error & ~exc_flush_all & ~((state_q == HOLD) & pend_exc_q);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q     <= RUN;
      pc_q        <= RESET_VECTOR;
      cnt_q       <= grp_cnt(RESET_VECTOR);
      delot_q     <= 2'b00;
      fp_q        <= 1'b0;
      refetch_q   <= 1'b0;
      valid_q     <= 1'b1;
      pend_pc_q   <= '0;
      pend_ds_q   <= 1'b0;
      pend_tgt_q  <= '0;
      pend_exc_q  <= 1'b0;
      dslot_tgt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      delot_q     <= delot_d;
      fp_q        <= fp_d;
      refetch_q   <= refetch_d;
      valid_q     <= 1'b1;
      pend_pc_q   <= pend_pc_d;
      pend_ds_q   <= pend_ds_d;
      pend_tgt_q  <= pend_tgt_d;
      pend_exc_q  <= pend_exc_d;
      dslot_tgt_q <= dslot_tgt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    delot_d     = delot_q;
    fp_d        = fp_q;
    refetch_d   = refetch_q;
    pend_pc_d   = pend_pc_q;
    pend_ds_d   = pend_ds_q;
    pend_tgt_d  = pend_tgt_q;
    pend_exc_d  = pend_exc_q;
    dslot_tgt_d = dslot_tgt_q;
    redir       = 1'b1;
    npc         = seq_pc(pc_q);
    nstate      = RUN;

    if (!advance) begin
      // Stalled: latch EX/CP0 redirects, everything else waits.
      if (exc_flush_all) begin
        state_d    = HOLD;
        fp_d       = 1'b1;
        delot_d    = 2'b00;
        pend_pc_d  = cp0_if_excaddr;
        pend_ds_d  = 1'b0;
        pend_exc_d = 1'b1;
      end else if (mispredict) begin
        state_d    = HOLD;
        fp_d       = 1'b1;
        delot_d    = 2'b00;
        pend_pc_d  = ex_delot_en ? ex_delot_pc : ex_new_target;
        pend_ds_d  = ex_delot_en;
        pend_tgt_d = ex_new_target;
        pend_exc_d = 1'b0;
      end
    end else begin
      if (exc_flush_all) begin
        npc = cp0_if_excaddr;
      end else if (mispredict) begin
        if (ex_delot_en) begin
          npc         = ex_delot_pc;
          nstate      = DSLOT_EX;
          dslot_tgt_d = ex_new_target;
        end else begin
          npc = ex_new_target;
        end
      end else begin
        case (state_q)
          HOLD: begin
            npc = pend_pc_q;
            if (pend_ds_q) begin
              nstate      = DSLOT_EX;
              dslot_tgt_d = pend_tgt_q;
            end
          end
          DSLOT_EX, DSLOT_BP: npc = dslot_tgt_q;
          default: begin
            if (bp_if_delot_en) begin
              npc         = bp_if_delot_pc;
              nstate      = DSLOT_BP;
              dslot_tgt_d = bp_if_target;
            end else if (bp_if_en) begin
              npc = bp_if_target;
            end else begin
              redir = 1'b0;
            end
          end
        endcase
      end

      state_d    = nstate;
      pc_d       = npc;
      cnt_d      = (nstate == RUN) ? grp_cnt(npc) : CNT_W'(1);
      delot_d    = (nstate == DSLOT_EX) ? 2'b10 : (nstate == DSLOT_BP) ? 2'b01 : 2'b00;
      fp_d       = 1'b0;
      pend_ds_d  = 1'b0;
      pend_exc_d = 1'b0;
      refetch_d  = redir & (npc == pc_q) & (npc != '0);
    end
  end

  assign if_pc              = pc_q;
  assign if_valid_ns        = valid_q;
  assign if_word_cnt        = cnt_q;
  assign if_icache_delot_en = delot_q;
  assign flush_pending      = fp_q;
  assign refetch_flag       = refetch_q;

endmodule

// File: tb/tb_if_fetch_gen.sv
// Bench for if_fetch_gen: directed vector table on FETCH_W=4 plus random
// stimulus on FETCH_W=1/4/8 against a behavioural fetch model.
module tb_if_fetch_gen;

  localparam logic [31:0] RV = 32'hBFC0_0000;

  typedef struct {
    bit exc; logic [31:0] excaddr;
    bit exb; logic [31:0] tgt; bit dse; logic [31:0] dspc;
    bit bpe; logic [31:0] bpt; bit bpde; logic [31:0] bpdpc;
    bit ic; bit ba;
  } in_t;

  typedef struct {
    in_t i; logic [31:0] pc; int cnt; logic [1:0] de; bit fp; bit rf;
  } vec_t;

  // Model modes: 0 normal, 1 redirect held, 2 EX delay slot, 3 BPU delay slot.
  typedef struct {
    logic [31:0] pc; int cnt; logic [1:0] de; bit fp; bit rf; int mode;
    logic [31:0] ppc; bit pds; logic [31:0] ptgt; bit pexc; logic [31:0] tgt;
  } mdl_t;

  logic clk = 1'b0, rst_;
  logic exc_flush_all, ex_bp_error, ex_delot_en, bp_if_en, bp_if_delot_en, icache_allin, bp_allin;
  logic [31:0] cp0_if_excaddr, ex_new_target, ex_delot_pc, bp_if_target, bp_if_delot_pc;

  logic [31:0] pc1, pc4, pc8;
  logic v1, v4, v8, fp1, fp4, fp8, rf1, rf4, rf8;
  logic [0:0] cnt1; logic [2:0] cnt4; logic [3:0] cnt8;
  logic [1:0] de1, de4, de8;

  int checks = 0, errors = 0;
  in_t cur;
  mdl_t m1, m4, m8;
  vec_t tbl[$];

  always #5 clk = ~clk;

  if_fetch_gen #(.ADDR_W(32), .FETCH_W(1), .RESET_VECTOR(RV)) u1 (
    .clk(clk), .rst_(rst_), .exc_flush_all(exc_flush_all), .cp0_if_excaddr(cp0_if_excaddr),
    .ex_bp_error(ex_bp_error), .ex_new_target(ex_new_target), .ex_delot_en(ex_delot_en),
    .ex_delot_pc(ex_delot_pc), .bp_if_en(bp_if_en), .bp_if_target(bp_if_target),
    .bp_if_delot_en(bp_if_delot_en), .bp_if_delot_pc(bp_if_delot_pc), .icache_allin(icache_allin),
    .bp_allin(bp_allin), .if_pc(pc1), .if_valid_ns(v1), .if_word_cnt(cnt1),
    .if_icache_delot_en(de1), .flush_pending(fp1), .refetch_flag(rf1));

  if_fetch_gen #(.ADDR_W(32), .FETCH_W(4), .RESET_VECTOR(RV)) u4 (
    .clk(clk), .rst_(rst_), .exc_flush_all(exc_flush_all), .cp0_if_excaddr(cp0_if_excaddr),
    .ex_bp_error(ex_bp_error), .ex_new_target(ex_new_target), .ex_delot_en(ex_delot_en),
    .ex_delot_pc(ex_delot_pc), .bp_if_en(bp_if_en), .bp_if_target(bp_if_target),
    .bp_if_delot_en(bp_if_delot_en), .bp_if_delot_pc(bp_if_delot_pc), .icache_allin(icache_allin),
    .bp_allin(bp_allin), .if_pc(pc4), .if_valid_ns(v4), .if_word_cnt(cnt4),
    .if_icache_delot_en(de4), .flush_pending(fp4), .refetch_flag(rf4));

  if_fetch_gen #(.ADDR_W(32), .FETCH_W(8), .RESET_VECTOR(RV)) u8 (
    .clk(clk), .rst_(rst_), .exc_flush_all(exc_flush_all), .cp0_if_excaddr(cp0_if_excaddr),
    .ex_bp_error(ex_bp_error), .ex_new_target(ex_new_target), .ex_delot_en(ex_delot_en),
    .ex_delot_pc(ex_delot_pc), .bp_if_en(bp_if_en), .bp_if_target(bp_if_target),
    .bp_if_delot_en(bp_if_delot_en), .bp_if_delot_pc(bp_if_delot_pc), .icache_allin(icache_allin),
    .bp_allin(bp_allin), .if_pc(pc8), .if_valid_ns(v8), .if_word_cnt(cnt8),
    .if_icache_delot_en(de8), .flush_pending(fp8), .refetch_flag(rf8));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int words_left(input logic [31:0] pc, input int fw);
    return fw - int'((pc % (4 * fw)) / 4);
  endfunction

  function automatic mdl_t mdl_reset(input int fw);
    mdl_t m;
    m = '{pc: RV, cnt: words_left(RV, fw), de: 2'b00, fp: 0, rf: 0, mode: 0,
          ppc: '0, pds: 0, ptgt: '0, pexc: 0, tgt: '0};
    return m;
  endfunction

  // Behavioural next state: stall latches EX/CP0 redirects, advance applies the
  // highest-priority source; sequential step is the next 4*fw-byte boundary.
  function automatic mdl_t mdl_step(input mdl_t m, input in_t i, input int fw);
    mdl_t n;
    bit exb, redir;
    logic [31:0] npc, blk;
    int nmode;
    n = m;
    exb = i.exb && !i.exc && !(m.mode == 1 && m.pexc);
    if (!(i.ic && i.ba)) begin
      if (i.exc) begin
        n.mode = 1; n.fp = 1; n.de = 2'b00; n.ppc = i.excaddr; n.pds = 0; n.pexc = 1;
      end else if (exb) begin
        n.mode = 1; n.fp = 1; n.de = 2'b00; n.ppc = i.dse ? i.dspc : i.tgt;
        n.pds = i.dse; n.ptgt = i.tgt; n.pexc = 0;
      end
      return n;
    end
    blk = 32'(4 * fw);
    redir = 1; nmode = 0;
    if (i.exc) npc = i.excaddr;
    else if (exb && i.dse) begin npc = i.dspc; nmode = 2; n.tgt = i.tgt; end
    else if (exb) npc = i.tgt;
    else if (m.mode == 1) begin
      npc = m.ppc;
      if (m.pds) begin nmode = 2; n.tgt = m.ptgt; end
    end
    else if (m.mode >= 2) npc = m.tgt;
    else if (i.bpde) begin npc = i.bpdpc; nmode = 3; n.tgt = i.bpt; end
    else if (i.bpe) npc = i.bpt;
    else begin npc = (m.pc / blk + 32'd1) * blk; redir = 0; end
    n.rf = redir && (npc == m.pc) && (npc != 0);
    n.pc = npc; n.mode = nmode; n.fp = 0; n.pds = 0; n.pexc = 0;
    n.de = (nmode == 2) ? 2'b10 : (nmode == 3) ? 2'b01 : 2'b00;
    n.cnt = (nmode >= 2) ? 1 : words_left(npc, fw);
    return n;
  endfunction

  task automatic cmp(input string tag, input mdl_t m, input logic [31:0] pc, input int cnt,
                     input logic [1:0] de, input logic fp, input logic rf, input logic v);
    chk({tag, "_pc"}, pc, m.pc);
    chk({tag, "_cnt"}, 32'(cnt), 32'(m.cnt));
    chk({tag, "_delot"}, 32'(de), 32'(m.de));
    chk({tag, "_fp"}, 32'(fp), 32'(m.fp));
    chk({tag, "_refetch"}, 32'(rf), 32'(m.rf));
    chk({tag, "_valid"}, 32'(v), 32'd1);
  endtask

  task automatic cmp_all();
    cmp("w1", m1, pc1, int'(cnt1), de1, fp1, rf1, v1);
    cmp("w4", m4, pc4, int'(cnt4), de4, fp4, rf4, v4);
    cmp("w8", m8, pc8, int'(cnt8), de8, fp8, rf8, v8);
  endtask

  task automatic drive(input in_t i);
    cur = i;
    exc_flush_all = i.exc; cp0_if_excaddr = i.excaddr;
    ex_bp_error = i.exb; ex_new_target = i.tgt; ex_delot_en = i.dse; ex_delot_pc = i.dspc;
    bp_if_en = i.bpe; bp_if_target = i.bpt; bp_if_delot_en = i.bpde; bp_if_delot_pc = i.bpdpc;
    icache_allin = i.ic; bp_allin = i.ba;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_) begin
      m1 = mdl_step(m1, cur, 1);
      m4 = mdl_step(m4, cur, 4);
      m8 = mdl_step(m8, cur, 8);
    end
    @(negedge clk);
    cmp_all();
  endtask

  function automatic in_t idle(input bit ic);
    in_t i;
    i = '{exc: 0, excaddr: '0, exb: 0, tgt: '0, dse: 0, dspc: '0,
          bpe: 0, bpt: '0, bpde: 0, bpdpc: '0, ic: ic, ba: 1};
    return i;
  endfunction

  task automatic row(input in_t i, input logic [31:0] pc, input int cnt, input logic [1:0] de,
                     input bit fp, input bit rf);
    vec_t v;
    v.i = i; v.pc = pc; v.cnt = cnt; v.de = de; v.fp = fp; v.rf = rf;
    tbl.push_back(v);
  endtask

  function automatic logic [31:0] rnd_addr();
    if ($urandom_range(0, 7) == 0) return m4.pc;
    return $urandom() & 32'hFFFF_FFFC;
  endfunction

  initial begin
    in_t t;
    drive(idle(1));
    rst_ = 1'b1;
    #1 rst_ = 1'b0;
    m1 = mdl_reset(1); m4 = mdl_reset(4); m8 = mdl_reset(8);
    repeat (2) @(negedge clk);
    chk("rst_pc", pc4, RV);
    chk("rst_cnt4", 32'(cnt4), 32'd4);
    chk("rst_cnt1", 32'(cnt1), 32'd1);
    chk("rst_cnt8", 32'(cnt8), 32'd8);
    chk("rst_delot", 32'(de4), 32'd0);
    chk("rst_fp", 32'(fp4), 32'd0);
    chk("rst_refetch", 32'(rf4), 32'd0);
    chk("rst_valid", 32'(v4), 32'd1);
    rst_ = 1'b1;

    // Directed vectors for the FETCH_W=4 instance.
    row(idle(1), 32'hBFC0_0010, 4, 2'b00, 0, 0);
    row(idle(1), 32'hBFC0_0020, 4, 2'b00, 0, 0);
    t = idle(1); t.bpe = 1; t.bpt = 32'hBFC0_0108;
    row(t, 32'hBFC0_0108, 2, 2'b00, 0, 0);
    row(idle(1), 32'hBFC0_0110, 4, 2'b00, 0, 0);
    t = idle(0); t.exb = 1; t.tgt = 32'h8000_1000;
    row(t, 32'hBFC0_0110, 4, 2'b00, 1, 0);
    row(idle(0), 32'hBFC0_0110, 4, 2'b00, 1, 0);
    row(idle(0), 32'hBFC0_0110, 4, 2'b00, 1, 0);
    row(idle(1), 32'h8000_1000, 4, 2'b00, 0, 0);
    t = idle(1); t.exb = 1; t.dse = 1; t.dspc = 32'h8000_200C; t.tgt = 32'h8000_3000;
    row(t, 32'h8000_200C, 1, 2'b10, 0, 0);
    row(idle(1), 32'h8000_3000, 4, 2'b00, 0, 0);
    t = idle(0); t.exb = 1; t.tgt = 32'h8000_5000;
    row(t, 32'h8000_3000, 4, 2'b00, 1, 0);
    t = idle(0); t.exc = 1; t.excaddr = 32'hBFC0_0380;
    row(t, 32'h8000_3000, 4, 2'b00, 1, 0);
    row(idle(1), 32'hBFC0_0380, 4, 2'b00, 0, 0);
    row(idle(1), 32'hBFC0_0390, 4, 2'b00, 0, 0);
    t = idle(1); t.bpe = 1; t.bpde = 1; t.bpdpc = 32'hBFC0_03A0; t.bpt = 32'hBFC0_0800;
    row(t, 32'hBFC0_03A0, 1, 2'b01, 0, 0);
    row(idle(1), 32'hBFC0_0800, 4, 2'b00, 0, 0);
    t = idle(1); t.exb = 1; t.tgt = 32'hBFC0_0800;
    row(t, 32'hBFC0_0800, 4, 2'b00, 0, 1);
    row(idle(1), 32'hBFC0_0810, 4, 2'b00, 0, 0);

    foreach (tbl[k]) begin
      drive(tbl[k].i);
      cycle();
      chk($sformatf("vec%0d_pc", k), pc4, tbl[k].pc);
      chk($sformatf("vec%0d_cnt", k), 32'(cnt4), 32'(tbl[k].cnt));
      chk($sformatf("vec%0d_delot", k), 32'(de4), 32'(tbl[k].de));
      chk($sformatf("vec%0d_fp", k), 32'(fp4), 32'(tbl[k].fp));
      chk($sformatf("vec%0d_refetch", k), 32'(rf4), 32'(tbl[k].rf));
    end

    // Asynchronous reset in the middle of a BPU delay-slot fetch.
    t = idle(1); t.bpde = 1; t.bpdpc = 32'h8000_0040; t.bpt = 32'h8000_0800;
    drive(t);
    cycle();
    chk("dbp_delot", 32'(de4), 32'd1);
    drive(idle(1));
    #2 rst_ = 1'b0;
    #1;
    chk("arst_pc", pc4, RV);
    chk("arst_delot", 32'(de4), 32'd0);
    chk("arst_cnt", 32'(cnt4), 32'd4);
    chk("arst_fp", 32'(fp4), 32'd0);
    m1 = mdl_reset(1); m4 = mdl_reset(4); m8 = mdl_reset(8);
    @(negedge clk);
    rst_ = 1'b1;
    chk("arst_hold_pc", pc4, RV);
    cycle();
    chk("arst_next_pc", pc4, 32'hBFC0_0010);
    chk("arst_next_pc1", pc1, 32'hBFC0_0004);
    chk("arst_next_pc8", pc8, 32'hBFC0_0020);

    // Random traffic, all three widths against the model.
    for (int n = 0; n < 3000; n++) begin
      t.exc = ($urandom_range(0, 40) == 0); t.excaddr = rnd_addr();
      t.exb = ($urandom_range(0, 12) == 0); t.tgt = rnd_addr();
      t.dse = $urandom_range(0, 1) == 1; t.dspc = rnd_addr();
      t.bpe = ($urandom_range(0, 5) == 0); t.bpt = rnd_addr();
      t.bpde = ($urandom_range(0, 10) == 0); t.bpdpc = rnd_addr();
      t.ic = ($urandom_range(0, 3) != 0); t.ba = ($urandom_range(0, 3) != 0);
      drive(t);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
